uart_rx_controller: RTL and testbench
=====================================

// Module: uart_rx_controller
// PURPOSE
//   Sequencing FSM for the UART receive path in the SPI/UART configurable link.
//   Synchronises the serial line, detects and validates start bits, times
//   mid-bit sampling, shifts 8 data bits LSB-first and checks the stop bit.
//   Outputs a data-valid pulse with the received byte, or a framing-error pulse.
//   Drives the 3-bit state and 16-bit clock count used by the rx_dv qualifier.
// PARAMETERS
//   CLKS_PER_BIT  87  clock cycles per bit period; legal range 2..65535
// PORTS
//   i_Clock        in   1   system clock, all logic on rising edge
//   i_Rst_n        in   1   asynchronous active-low reset
//   i_Enable       in   1   1 = UART mode active; 0 = receiver held in IDLE
//   i_Rx_Serial    in   1   raw serial line, idle high, asynchronous
//   o_Rx_DV        out  1   one-cycle pulse: o_Rx_Byte is valid
//   o_Rx_Byte      out  8   last received byte, held until next valid frame
//   o_Frame_Err    out  1   one-cycle pulse: stop bit sampled low
//   o_Busy         out  1   1 whenever state != IDLE
//   o_SM_State     out  3   current state encoding (debug and rx_dv qualifier)
//   o_Clock_Count  out  16  current bit-timing counter value
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, sync flops = 1, counter 0,
//     bit index 0, shift reg 0, o_Rx_Byte 0; all pulses and o_Busy are 0.
//   - Input sync: 2-flop synchronizer on i_Rx_Serial, reset value 1. FSM uses
//     only the synced bit rx_s, so line-to-FSM latency is 2 cycles.
//   - States: IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, CLEANUP=3'b100.
//   - IDLE: counter = 0, bit index = 0. If i_Enable && rx_s==0, go to START.
//   - START: counter counts up. When counter == (CLKS_PER_BIT-1)/2 (integer):
//       rx_s==0 -> DATA with counter cleared; rx_s==1 -> IDLE (glitch rejected).
//   - DATA: counter counts up. When counter == CLKS_PER_BIT-1, sample rx_s
//     into shift[bit index] (LSB first) and clear counter. If bit index == 7,
//     clear bit index and go to STOP; otherwise increment bit index.
//   - STOP: counter counts up. When counter == CLKS_PER_BIT-1:
//       rx_s==1 -> o_Rx_DV=1 for that cycle and o_Rx_Byte <= shift register;
//       rx_s==0 -> o_Frame_Err=1 for that cycle and o_Rx_Byte is unchanged.
//     Both cases go to CLEANUP with counter cleared.
//   - Pulse timing: o_Rx_DV and o_Frame_Err are combinational on the STOP
//     terminal cycle, exactly when state==3'b011 and count==CLKS_PER_BIT-1.
//     Therefore o_Rx_DV == (o_SM_State==3'b011 && o_Clock_Count==CLKS_PER_BIT-1
//     && rx_s). o_Rx_Byte must be updated no later than the same cycle.
//   - CLEANUP: lasts exactly 1 cycle, then goes to IDLE. A new start bit is
//     accepted from IDLE on the following cycle.
//   - Counter: 16-bit unsigned, cleared on every state transition, never wraps
//     (the terminal compare always fires first).
//   - i_Enable low in any state: synchronous return to IDLE on the next edge.
//     Partial byte is discarded, no pulses, o_Rx_Byte is unchanged.
//   - Async reset mid-frame: immediate return to reset values. The rest of the
//     frame is treated as line noise; a later low level can start a new frame.
//   - o_Rx_DV and o_Frame_Err are mutually exclusive and never asserted on
//     consecutive cycles.
// TESTING
//   (CLKS_PER_BIT=4 unless noted; a frame is 1 start, 8 data, 1 stop bit,
//   each bit 4 clocks)
//   1 Send byte 8'hA5 -> exactly one o_Rx_DV pulse, o_Rx_Byte==8'hA5,
//     o_Frame_Err never asserted, o_Busy returns to 0 one cycle after CLEANUP.
//   2 Send 8'h3C with stop bit driven 0 -> one o_Frame_Err pulse, no o_Rx_DV,
//     o_Rx_Byte keeps previous value 8'hA5.
//   3 Drive line low for 1 clock, then high -> FSM enters START and returns to
//     IDLE, with no pulses and no change to o_Rx_Byte.
//   4 Send 8'h00, 8'hFF, 8'h81 back-to-back with no idle gap -> three o_Rx_DV
//     pulses with bytes in order; o_Rx_DV == qualifier expression every cycle.
//   5 Deassert i_Enable in DATA after 3 bits (later: i_Rst_n low after 5 bits),
//     then send 8'h5A -> no pulse for the aborted frame; 8'h5A received cleanly.
//   6 CLKS_PER_BIT=87 and 2, random bytes -> scoreboard match on all bytes;
//     counter never exceeds CLKS_PER_BIT-1.

Source files
------------

// File: rtl/uart_rx_controller_if.sv
// Receive-path signal bundle for the UART receiver.
// The link controller drives enable and the line; the receiver returns frame results.
interface uart_rx_controller_if;
    logic        i_Enable;
    logic        i_Rx_Serial;
    logic        o_Rx_DV;
    logic [7:0]  o_Rx_Byte;
    logic        o_Frame_Err;
    logic        o_Busy;
    logic [2:0]  o_SM_State;
    logic [15:0] o_Clock_Count;

    modport master (
        output i_Enable,
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Frame_Err,
        input  o_Busy,
        input  o_SM_State,
        input  o_Clock_Count
    );

    modport slave (
        input  i_Enable,
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Frame_Err,
        output o_Busy,
        output o_SM_State,
        output o_Clock_Count
    );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: line sync, start validation, mid-bit sampling,
// LSB-first shift of 8 data bits and stop-bit check.
module uart_rx_controller #(
    parameter int CLKS_PER_BIT = 87
) (
    input logic               i_Clock,
    input logic               i_Rst_n,
    uart_rx_controller_if.slave rx
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] count;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  byte_q;
    logic        stop_hit;
    logic        dv;
    logic        fe;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx.i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            count   <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            byte_q  <= 8'd0;
        end else if (!rx.i_Enable) begin
            state   <= IDLE;
            count   <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    count   <= 16'd0;
                    bit_idx <= 3'd0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (count == HALF) begin
                        count <= 16'd0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                DATA: begin
                    if (count == LAST) begin
                        count          <= 16'd0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                STOP: begin
                    if (count == LAST) begin
                        count <= 16'd0;
                        state <= CLEANUP;
                        if (rx_s)
                            byte_q <= shift;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                CLEANUP: begin
                    count <= 16'd0;
                    state <= IDLE;
                end
                default: begin
                    count <= 16'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pulses live on the STOP terminal cycle; the byte bypasses so it is valid alongside.
    assign stop_hit = rx.i_Enable && (state == STOP) && (count == LAST);
    assign dv       = stop_hit && rx_s;
    assign fe       = stop_hit && !rx_s;

    assign rx.o_Rx_DV       = dv;
    assign rx.o_Frame_Err   = fe;
    assign rx.o_Rx_Byte     = dv ? shift : byte_q;
    assign rx.o_Busy        = (state != IDLE);
    assign rx.o_SM_State    = state;
    assign rx.o_Clock_Count = count;
endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at CLKS_PER_BIT of 4, 87 and 2.
// Unit 0 carries the directed scenarios, units 1 and 2 the random-byte runs.
module tb_uart_rx_controller;
    logic clk = 1'b0;
    logic rst_n;

    logic        ser    [3];
    logic        en     [3];
    logic        dv_a   [3];
    logic        fe_a   [3];
    logic        busy_a [3];
    logic        rxs_a  [3];
    logic [7:0]  byte_a [3];
    logic [2:0]  st_a   [3];
    logic [15:0] cnt_a  [3];

    int n_chk = 0;
    int n_fail = 0;

    int         dv_cnt    [3];
    int         fe_cnt    [3];
    int         bad_pulse [3];
    int         qual_bad  [3];
    int         max_cnt   [3];
    bit         prev_p    [3];
    logic [7:0] got_q     [3][$];

    function automatic int cpb_of(int k);
        return (k == 0) ? 4 : ((k == 1) ? 87 : 2);
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_controller_if bus ();

        assign bus.i_Enable    = en[g];
        assign bus.i_Rx_Serial = ser[g];
        assign dv_a[g]         = bus.o_Rx_DV;
        assign fe_a[g]         = bus.o_Frame_Err;
        assign busy_a[g]       = bus.o_Busy;
        assign byte_a[g]       = bus.o_Rx_Byte;
        assign st_a[g]         = bus.o_SM_State;
        assign cnt_a[g]        = bus.o_Clock_Count;

        uart_rx_controller #(
            .CLKS_PER_BIT(g == 0 ? 4 : (g == 1 ? 87 : 2))
        ) u_dut (
            .i_Clock(clk),
            .i_Rst_n(rst_n),
            .rx     (bus.slave)
        );

        assign rxs_a[g] = u_dut.rx_s;
    end

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv_a[k] === 1'b1) begin
                dv_cnt[k]++;
                got_q[k].push_back(byte_a[k]);
            end
            if (fe_a[k] === 1'b1)
                fe_cnt[k]++;
            if ((dv_a[k] && fe_a[k]) || ((dv_a[k] || fe_a[k]) && prev_p[k]))
                bad_pulse[k]++;
            prev_p[k] = (dv_a[k] === 1'b1) || (fe_a[k] === 1'b1);
            if (dv_a[k] !== (en[k] && st_a[k] == 3'b011
                    && cnt_a[k] == 16'(cpb_of(k) - 1) && rxs_a[k]))
                qual_bad[k]++;
            if (int'(cnt_a[k]) > max_cnt[k])
                max_cnt[k] = int'(cnt_a[k]);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(int k, logic [7:0] b, logic stop_bit, int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ser[k] = fr[i];
            repeat (cpb_of(k)) @(posedge clk);
            #1;
        end
        ser[k] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (st_a[k] !== 3'd0 || cnt_a[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_state u%0d got st=%0d cnt=%0d want 0 0", k, st_a[k], cnt_a[k]);
            end
            n_chk++;
            if (byte_a[k] !== 8'h00 || busy_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out u%0d got byte=%h busy=%b want 00 0", k, byte_a[k], busy_a[k]);
            end
            n_chk++;
            if (dv_a[k] !== 1'b0 || fe_a[k] !== 1'b0 || rxs_a[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_pulse u%0d got dv=%b fe=%b rx_s=%b want 0 0 1", k, dv_a[k], fe_a[k], rxs_a[k]);
            end
        end
        rst_n = 1'b1;
        cyc(3);
        n_chk++;
        if (st_a[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %0d want 0", st_a[0]);
        end
    endtask

    task automatic test_single();
        int d0 = dv_cnt[0];
        int f0 = fe_cnt[0];
        logic [7:0] g;
        send(0, 8'hA5, 1'b1, 10);
        cyc(1);
        n_chk++;
        if (st_a[0] !== 3'd4 || busy_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cleanup got st=%0d busy=%b want 4 1", st_a[0], busy_a[0]);
        end
        cyc(1);
        n_chk++;
        if (st_a[0] !== 3'd0 || busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got st=%0d busy=%b want 0 0", st_a[0], busy_a[0]);
        end
        n_chk++;
        if (dv_cnt[0] - d0 !== 1 || fe_cnt[0] !== f0) begin
            n_fail++;
            $display("FAIL single_pulses got dv=%0d fe=%0d want 1 0", dv_cnt[0] - d0, fe_cnt[0] - f0);
        end
        g = (got_q[0].size() > 0) ? got_q[0].pop_front() : 8'hxx;
        n_chk++;
        if (g !== 8'hA5 || byte_a[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_byte got pulse=%h held=%h want a5", g, byte_a[0]);
        end
    endtask

    task automatic test_frame_err();
        int d0 = dv_cnt[0];
        int f0 = fe_cnt[0];
        send(0, 8'h3C, 1'b0, 10);
        cyc(4);
        n_chk++;
        if (fe_cnt[0] - f0 !== 1 || dv_cnt[0] !== d0) begin
            n_fail++;
            $display("FAIL ferr_pulses got fe=%0d dv=%0d want 1 0", fe_cnt[0] - f0, dv_cnt[0] - d0);
        end
        n_chk++;
        if (byte_a[0] !== 8'hA5 || st_a[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL ferr_hold got byte=%h st=%0d want a5 0", byte_a[0], st_a[0]);
        end
    endtask

    task automatic test_glitch();
        int d0 = dv_cnt[0];
        int f0 = fe_cnt[0];
        ser[0] = 1'b0;
        cyc(1);
        ser[0] = 1'b1;
        cyc(2);
        n_chk++;
        if (st_a[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL glitch_start got %0d want 1", st_a[0]);
        end
        cyc(2);
        n_chk++;
        if (st_a[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch_reject got %0d want 0", st_a[0]);
        end
        cyc(6);
        n_chk++;
        if (dv_cnt[0] !== d0 || fe_cnt[0] !== f0 || byte_a[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL glitch_quiet got dv=%0d fe=%0d byte=%h want 0 0 a5",
                     dv_cnt[0] - d0, fe_cnt[0] - f0, byte_a[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        logic [7:0] g;
        int d0 = dv_cnt[0];
        exp = '{8'h00, 8'hFF, 8'h81};
        for (int i = 0; i < 3; i++)
            send(0, exp[i], 1'b1, 10);
        cyc(4);
        n_chk++;
        if (dv_cnt[0] - d0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 3", dv_cnt[0] - d0);
        end
        for (int i = 0; i < 3; i++) begin
            g = (got_q[0].size() > 0) ? got_q[0].pop_front() : 8'hxx;
            n_chk++;
            if (g !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_byte%0d got %h want %h", i, g, exp[i]);
            end
        end
        n_chk++;
        if (qual_bad[0] !== 0 || bad_pulse[0] !== 0) begin
            n_fail++;
            $display("FAIL b2b_qualifier got qual=%0d pulse=%0d want 0 0", qual_bad[0], bad_pulse[0]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] g;
        int d0 = dv_cnt[0];
        int f0 = fe_cnt[0];
        send(0, 8'hC3, 1'b1, 5);
        n_chk++;
        if (st_a[0] !== 3'd2) begin
            n_fail++;
            $display("FAIL abort_in_data got %0d want 2", st_a[0]);
        end
        en[0] = 1'b0;
        cyc(1);
        n_chk++;
        if (st_a[0] !== 3'd0 || busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_enable got st=%0d busy=%b want 0 0", st_a[0], busy_a[0]);
        end
        cyc(20);
        en[0] = 1'b1;
        cyc(4);
        n_chk++;
        if (dv_cnt[0] !== d0 || fe_cnt[0] !== f0 || byte_a[0] !== 8'h81) begin
            n_fail++;
            $display("FAIL abort_quiet got dv=%0d fe=%0d byte=%h want 0 0 81",
                     dv_cnt[0] - d0, fe_cnt[0] - f0, byte_a[0]);
        end
        send(0, 8'h5A, 1'b1, 10);
        cyc(4);
        g = (got_q[0].size() > 0) ? got_q[0].pop_front() : 8'hxx;
        n_chk++;
        if (dv_cnt[0] - d0 !== 1 || g !== 8'h5A) begin
            n_fail++;
            $display("FAIL abort_en_recover got n=%0d byte=%h want 1 5a", dv_cnt[0] - d0, g);
        end
        send(0, 8'hC3, 1'b1, 6);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (st_a[0] !== 3'd0 || byte_a[0] !== 8'h00 || busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rst got st=%0d byte=%h busy=%b want 0 00 0", st_a[0], byte_a[0], busy_a[0]);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        d0 = dv_cnt[0];
        send(0, 8'h5A, 1'b1, 10);
        cyc(4);
        g = (got_q[0].size() > 0) ? got_q[0].pop_front() : 8'hxx;
        n_chk++;
        if (dv_cnt[0] - d0 !== 1 || g !== 8'h5A || byte_a[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL abort_rst_recover got n=%0d byte=%h held=%h want 1 5a 5a",
                     dv_cnt[0] - d0, g, byte_a[0]);
        end
    endtask

    task automatic test_random_rates();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        logic [7:0] g;
        for (int k = 1; k < 3; k++) begin
            int d0 = dv_cnt[k];
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send(k, b, 1'b1, 10);
                cyc(8);
            end
            n_chk++;
            if (dv_cnt[k] - d0 !== 4 || fe_cnt[k] !== 0) begin
                n_fail++;
                $display("FAIL rate%0d_count got dv=%0d fe=%0d want 4 0", cpb_of(k), dv_cnt[k] - d0, fe_cnt[k]);
            end
            for (int i = 0; i < 4; i++) begin
                g = (got_q[k].size() > 0) ? got_q[k].pop_front() : 8'hxx;
                n_chk++;
                if (g !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rate%0d_byte%0d got %h want %h", cpb_of(k), i, g, exp_q[i]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (max_cnt[k] > cpb_of(k) - 1) begin
                n_fail++;
                $display("FAIL counter_max u%0d got %0d want <= %0d", k, max_cnt[k], cpb_of(k) - 1);
            end
            n_chk++;
            if (qual_bad[k] !== 0 || bad_pulse[k] !== 0) begin
                n_fail++;
                $display("FAIL pulse_rules u%0d got qual=%0d pulse=%0d want 0 0", k, qual_bad[k], bad_pulse[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ser[k] = 1'b1;
            en[k]  = 1'b1;
        end
        cyc(1);
        test_reset();
        test_single();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_abort();
        test_random_rates();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
